// File: rtl/cache_fill_fsm_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm_if
//  Description : Signal bundle between the cache miss-fill controller and its
//                surroundings (pipeline miss detect, memory request/return
//                path, and the data/tag array write port).
//
//  Signals
//    miss_detected     pipeline -> ctrl   cache miss this cycle
//    miss_address      pipeline -> ctrl   byte address that missed
//    memory_data_valid memory   -> ctrl   memory_data carries a returned word
//    memory_data       memory   -> ctrl   returned word, in request order
//    fsm_busy          ctrl -> pipeline   fill in progress, pipeline stalls
//    mem_req           ctrl -> memory     memory_address is a read request
//    memory_address    ctrl -> memory     request byte address
//    write_data_array  ctrl -> arrays     data-array word write enable
//    word_index        ctrl -> arrays     data-array word being written
//    fill_data         ctrl -> arrays     word to write
//    write_tag_array   ctrl -> arrays     one-cycle tag/valid write strobe
//
//  Modports
//    master : the fill controller
//    slave  : the environment (pipeline, memory, storage arrays)
//
//  Revision    : 1.0  initial release
// ============================================================================
interface cache_fill_fsm_if #(
  parameter int IDX_W = 3
) ();

  logic              miss_detected;
  logic [15:0]       miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              mem_req;
  logic [15:0]       memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic [15:0]       fill_data;
  logic              write_tag_array;

  modport master (
    input  miss_detected,
    input  miss_address,
    input  memory_data_valid,
    input  memory_data,
    output fsm_busy,
    output mem_req,
    output memory_address,
    output write_data_array,
    output word_index,
    output fill_data,
    output write_tag_array
  );

  modport slave (
    output miss_detected,
    output miss_address,
    output memory_data_valid,
    output memory_data,
    input  fsm_busy,
    input  mem_req,
    input  memory_address,
    input  write_data_array,
    input  word_index,
    input  fill_data,
    input  write_tag_array
  );

endinterface

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cache_fill_fsm
//  Description : Cache miss-fill controller. On a miss it issues the WORDS
//                word-address read requests of the missing block, one per
//                cycle, streams the in-order returned words into the data
//                array with per-word write enables, and strobes the tag
//                write together with the last word. fsm_busy stalls the
//                pipeline for the whole fill.
//
//  Ports
//    clk    in   rising-edge clock
//    rst_n  in   asynchronous active-low reset
//    bus    cache_fill_fsm_if.master
//             in : miss_detected, miss_address, memory_data_valid,
//                  memory_data
//             out: fsm_busy, mem_req, memory_address, write_data_array,
//                  word_index, fill_data, write_tag_array
//
//  Parameters
//    WORDS  words per block (power of two), block bytes = 2*WORDS
//    IDX_W  log2(WORDS)
//
//  Revision    : 1.0  initial release
// ============================================================================
module cache_fill_fsm #(
  parameter int WORDS = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_fill_fsm_if.master  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [IDX_W:0] c_WORDS = (IDX_W+1)'(WORDS);
  localparam logic [IDX_W:0] c_LAST  = (IDX_W+1)'(WORDS - 1);

  // Clears the byte-within-block bits of a miss address.
  localparam logic [15:0] c_BLOCK_MASK = ~(16'(2 * WORDS - 1));

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]     r_state;
  logic [IDX_W:0] r_req_cnt;
  logic [IDX_W:0] r_rcv_cnt;
  logic [15:0]    r_base;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic           w_in_fill;
  logic           w_start;
  logic           w_req_active;
  logic           w_wr;
  logic           w_last;
  logic [15:0]    w_offset;

  assign w_in_fill    = (r_state == S_FILL);
  assign w_start      = (r_state == S_IDLE) && bus.miss_detected;
  assign w_req_active = w_in_fill && (r_req_cnt < c_WORDS);
  assign w_wr         = w_in_fill && bus.memory_data_valid;
  assign w_last       = w_wr && (r_rcv_cnt == c_LAST);

  // Byte offset of the current request within the block. OR-ing into the
  // aligned base (rather than adding) keeps the address inside the block,
  // so a block at the top of memory never carries out.
  assign w_offset = {{(15 - IDX_W){1'b0}}, r_req_cnt[IDX_W-1:0], 1'b0};

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_req_cnt <= '0;
      r_rcv_cnt <= '0;
      r_base    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_start) begin
        r_base    <= bus.miss_address & c_BLOCK_MASK;
        r_req_cnt <= '0;
        r_rcv_cnt <= '0;
        r_state   <= S_FILL;
      end
    end else begin
      // Requests are issued blindly one per cycle; memory latency is
      // unknown here, so returns are tracked by their own counter.
      if (r_req_cnt < c_WORDS) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
      if (bus.memory_data_valid) begin
        r_rcv_cnt <= r_rcv_cnt + 1'b1;
      end
      if (w_last) begin
        r_state <= S_IDLE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Everything except fill_data derives from state that the async reset
  // clears, so those outputs fall to zero as soon as rst_n drops. fill_data
  // is a pass-through of memory_data and is forced low under reset so the
  // whole port is quiet while reset is asserted.
  assign bus.fsm_busy         = w_in_fill;
  assign bus.mem_req          = w_req_active;
  assign bus.memory_address   = r_base | w_offset;
  assign bus.write_data_array = w_wr;
  assign bus.word_index       = r_rcv_cnt[IDX_W-1:0];
  assign bus.fill_data        = rst_n ? bus.memory_data : 16'h0000;
  assign bus.write_tag_array  = w_last;

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cache_fill_fsm
//  Description : Self-checking bench for cache_fill_fsm. Expected requests
//                and array writes are queued when a fill is started and
//                popped by a negedge monitor as the DUT produces them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_fill_fsm;

  localparam int WORDS = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic             tag;
    logic [IDX_W-1:0] idx;
    logic [15:0]      data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.IDX_W(IDX_W)) bus ();

  cache_fill_fsm #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] q_req[$];
  wr_t         q_wr[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every request / write the DUT makes must match the
  // head of the corresponding expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_req) begin
        n_cmp++;
        assert (q_req.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_req: observed addr %h expected no request", bus.memory_address);
        end
        if (q_req.size() != 0) check("req_addr", {16'h0, bus.memory_address}, {16'h0, q_req.pop_front()});
      end
      if (bus.write_data_array) begin
        n_cmp++;
        assert (q_wr.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_write: observed idx %0d data %h expected no write", bus.word_index, bus.fill_data);
        end
        if (q_wr.size() != 0)
          check("write_tag_idx_data", {12'h0, bus.write_tag_array, bus.word_index, bus.fill_data},
                {12'h0, q_wr.pop_front()});
      end else if (bus.write_tag_array) begin
        check("tag_without_write", {31'h0, bus.write_tag_array}, 32'h0);
      end
    end
  end

  // One complete fill. Valid returns start lat cycles into FILL; an optional
  // gap of gap_len cycles precedes word gap_at; a stray miss may be pulsed at
  // cycle stray_at, or held high throughout (hold_miss).
  task automatic do_fill(input logic [15:0] addr, input logic [15:0] dbase, input int lat,
                         input int gap_at, input int gap_len, input int stray_at, input bit hold_miss);
    logic [15:0] base;
    wr_t         e;
    int          w;
    int          c;
    int          gap_cnt;
    bit          v;
    base    = addr & 16'hFFF0;
    w       = 0;
    c       = 0;
    gap_cnt = 0;
    for (int i = 0; i < WORDS; i++) begin
      q_req.push_back(base + 16'(2 * i));
      e.tag  = (i == WORDS - 1);
      e.idx  = IDX_W'(i);
      e.data = dbase + 16'(i);
      q_wr.push_back(e);
    end
    bus.miss_detected     = 1'b1;
    bus.miss_address      = addr;
    bus.memory_data_valid = 1'b0;
    @(negedge clk);
    check("idle_before_fill_busy", {31'h0, bus.fsm_busy}, 32'h0);
    step();
    while (w < WORDS && c < 200) begin
      v = (c >= lat) && !(w == gap_at && gap_cnt < gap_len);
      if (c >= lat && w == gap_at && gap_cnt < gap_len) gap_cnt++;
      bus.memory_data_valid = v;
      bus.memory_data       = v ? dbase + 16'(w) : 16'($urandom);
      bus.miss_detected     = hold_miss || (c == stray_at);
      bus.miss_address      = 16'h4000;
      @(negedge clk);
      check("fill_busy", {31'h0, bus.fsm_busy}, 32'h1);
      step();
      if (v) w++;
      c++;
    end
    bus.memory_data_valid = 1'b0;
    bus.miss_detected     = hold_miss;
    check("req_queue_drained", q_req.size(), 0);
    check("wr_queue_drained", q_wr.size(), 0);
  endtask

  task automatic idle(input int n);
    bus.miss_detected = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", {31'h0, bus.fsm_busy}, 32'h0);
      check("idle_req", {31'h0, bus.mem_req}, 32'h0);
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'h0, bus.fsm_busy}, 32'h0);
    check({tag, "_req"}, {31'h0, bus.mem_req}, 32'h0);
    check({tag, "_addr"}, {16'h0, bus.memory_address}, 32'h0);
    check({tag, "_wr"}, {31'h0, bus.write_data_array}, 32'h0);
    check({tag, "_idx"}, {29'h0, bus.word_index}, 32'h0);
    check({tag, "_data"}, {16'h0, bus.fill_data}, 32'h0);
    check({tag, "_tag"}, {31'h0, bus.write_tag_array}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    bus.miss_detected     = 1'b1;
    bus.miss_address      = 16'h1234;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'h5A5A;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    step();

    // Stray valid while idle.
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_wr", {31'h0, bus.write_data_array}, 32'h0);
      check("stray_tag", {31'h0, bus.write_tag_array}, 32'h0);
      check("stray_busy", {31'h0, bus.fsm_busy}, 32'h0);
      step();
    end
    bus.memory_data_valid = 1'b0;

    // Basic fill, 4-cycle latency: 12 busy cycles then idle.
    do_fill(16'h1234, 16'hA000, 4, -1, 0, -1, 1'b0);
    idle(2);

    // Gapped returns before word 3.
    do_fill(16'h1230, 16'hC000, 4, 3, 3, -1, 1'b0);
    idle(1);

    // Miss at 0x4000 pulsed mid-fill is ignored.
    do_fill(16'h1230, 16'hD000, 2, -1, 0, 5, 1'b0);
    idle(3);

    // Reset after word 4 has been written.
    for (int i = 0; i < 6; i++) q_req.push_back(16'h5670 + 16'(2 * i));
    for (int i = 0; i < 5; i++) begin
      e.tag  = 1'b0;
      e.idx  = IDX_W'(i);
      e.data = 16'hB000 + 16'(i);
      q_wr.push_back(e);
    end
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h5678;
    step();
    bus.miss_detected = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.memory_data_valid = (c >= 1);
      bus.memory_data       = (c >= 1) ? 16'hB000 + 16'(c - 1) : 16'h0000;
      step();
    end
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hB005;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midfill_reset");
    check("reset_req_queue", q_req.size(), 0);
    check("reset_wr_queue", q_wr.size(), 0);
    bus.memory_data_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    do_fill(16'h0020, 16'hE000, 3, -1, 0, -1, 1'b0);
    idle(1);

    // Wrap at top of memory, miss held high for a back-to-back fill.
    do_fill(16'hFFFE, 16'hF000, 1, -1, 0, -1, 1'b1);
    do_fill(16'h2468, 16'h9000, 0, -1, 0, -1, 1'b0);
    idle(2);

    check("final_req_queue", q_req.size(), 0);
    check("final_wr_queue", q_wr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
